// File: rtl/lbp_pkg.sv
// -----------------------------------------------------------------------------
// lbp_pkg
// Shared definitions for the LBP scan controller:
//   - default image geometry (IMG_W, IMG_H, AW)
//   - scan FSM state encoding
//   - 3x3 window packing helpers. The window is 72 bits, row-major, with
//     [71:64] = top-left, [39:32] = centre and [7:0] = bottom-right.
// -----------------------------------------------------------------------------
package lbp_pkg;

  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int AW    = 14;
  localparam int WIN_W = 72;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW_INIT,
    ST_COL_FETCH,
    ST_WIN_OUT,
    ST_WAIT_RES,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Byte at window position (row, col), each in 0..2.
  function automatic logic [7:0] win_byte(input logic [WIN_W-1:0] w,
                                          input int unsigned row,
                                          input int unsigned col);
    return w[(8 - (row * 3 + col)) * 8 +: 8];
  endfunction

  // Shift every window row left by one pixel; the right column becomes zero.
  // Row i (0 = bottom) occupies w[i*24 +: 24] as {left, mid, right}.
  function automatic logic [WIN_W-1:0] win_shift_left(input logic [WIN_W-1:0] w);
    logic [WIN_W-1:0] s;
    s = '0;
    for (int i = 0; i < 3; i++) begin
      s[i*24 +: 24] = {w[i*24 +: 16], 8'h00};
    end
    return s;
  endfunction

  // Overwrite the right column. col = {top, middle, bottom}.
  function automatic logic [WIN_W-1:0] win_set_right(input logic [WIN_W-1:0] w,
                                                     input logic [23:0]      col);
    logic [WIN_W-1:0] s;
    s = w;
    for (int i = 0; i < 3; i++) begin
      s[i*24 +: 8] = col[i*8 +: 8];
    end
    return s;
  endfunction

endpackage

// File: rtl/lbp_win_buf.sv
// -----------------------------------------------------------------------------
// lbp_win_buf
// 3x3 byte window register. shift_i moves all columns one pixel left,
// load_i writes col_i into the right column; asserted together they slide the
// window one column to the right across the image.
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (window clears to zero)
//   shift_i  in   shift columns left
//   load_i   in   load col_i into right column
//   col_i    in   24-bit column {top, middle, bottom}
//   win_o    out  72-bit row-major window
// -----------------------------------------------------------------------------
module lbp_win_buf
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_i,
  input  logic              load_i,
  input  logic [23:0]       col_i,
  output logic [WIN_W-1:0]  win_o
);

  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_d;

  // NOTE: win_d takes its held value first so every path assigns it and no latch is inferred.
  always_comb begin
    win_d = win_q;
    if (shift_i) win_d = win_shift_left(win_d);
    if (load_i)  win_d = win_set_right(win_d, col_i);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  // NOTE: the window is a handful of flops, not a RAM, so it is reset to give win a defined zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) win_q <= '0;
    else        win_q <= win_d;
  end

  assign win_o = win_q;

endmodule

// File: rtl/lbp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// lbp_scan_ctrl
// Scans every interior pixel of an IMG_W x IMG_H gray image, fetches its 3x3
// neighbourhood from gray memory (1-cycle read latency), hands the window to
// the LBP compare unit and writes the returned code to LBP memory at the
// centre address. Raises a sticky finish after the last write.
//   clk         in   clock
//   reset       in   asynchronous active-low reset
//   gray_ready  in   gray memory available; gates new requests
//   gray_req    out  read request for gray_addr
//   gray_addr   out  read address {row, col}
//   gray_data   in   read data, valid the cycle after gray_req
//   win_valid   out  one-cycle pulse, win holds a complete window
//   win         out  72-bit row-major window
//   res_valid   in   compare unit result strobe (used only while waiting)
//   res_data    in   LBP code
//   lbp_valid   out  LBP memory write strobe
//   lbp_addr    out  write address {row, col} of window centre
//   lbp_data    out  write data
//   finish      out  scan complete, sticky until reset
// -----------------------------------------------------------------------------
module lbp_scan_ctrl
  import lbp_pkg::*;
#(
  parameter int IMG_W = lbp_pkg::IMG_W,
  parameter int IMG_H = lbp_pkg::IMG_H,
  parameter int AW    = lbp_pkg::AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [AW-1:0]     gray_addr,
  input  logic [7:0]        gray_data,
  output logic              win_valid,
  output logic [WIN_W-1:0]  win,
  input  logic              res_valid,
  input  logic [7:0]        res_data,
  output logic              lbp_valid,
  output logic [AW-1:0]     lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = AW - CW;
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 2);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 2);

  state_e         state_q;
  logic [RW-1:0]  r_q;
  logic [CW-1:0]  c_q;
  // Issue side: next row offset (0..2) and column offset within the fetch.
  logic [1:0]     iss_row_q;
  logic [1:0]     iss_col_q;
  // Capture side: row offset of the next datum and columns completed so far.
  logic [1:0]     cap_row_q;
  logic [1:0]     cap_col_q;
  logic           pend_q;       // a request went out last cycle; its data is on gray_data now
  logic [15:0]    stage_q;      // {top, middle} of the column being assembled

  logic              gray_req_q;
  logic [AW-1:0]     gray_addr_q;
  logic              win_valid_q;
  logic              lbp_valid_q;
  logic [AW-1:0]     lbp_addr_q;
  logic [7:0]        lbp_data_q;
  logic              finish_q;

  logic              fetching;
  logic [1:0]        n_cols;
  logic [CW-1:0]     req_col;
  logic [RW-1:0]     req_row;
  logic              issue;
  logic              cap_col_done;
  logic              win_done;

  // ROW_INIT fills all three columns starting at c-1; COL_FETCH brings in only c+1.
  assign fetching     = (state_q == ST_ROW_INIT) || (state_q == ST_COL_FETCH);
  assign n_cols       = (state_q == ST_ROW_INIT) ? 2'd3 : 2'd1;
  assign req_col      = ((state_q == ST_ROW_INIT) ? (c_q - CW'(1)) : (c_q + CW'(1)))
                        + CW'(iss_col_q);
  assign req_row      = r_q - RW'(1) + RW'(iss_row_q);
  assign issue        = fetching && gray_ready && (iss_col_q != n_cols);
  assign cap_col_done = fetching && pend_q && (cap_row_q == 2'd2);
  assign win_done     = cap_col_done && (cap_col_q == n_cols - 2'd1);

  lbp_win_buf u_win_buf (
    .clk     (clk),
    .rst_n   (reset),
    .shift_i (cap_col_done),
    .load_i  (cap_col_done),
    .col_i   ({stage_q, gray_data}),
    .win_o   (win)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      r_q         <= RW'(1);
      c_q         <= CW'(1);
      iss_row_q   <= '0;
      iss_col_q   <= '0;
      cap_row_q   <= '0;
      cap_col_q   <= '0;
      pend_q      <= 1'b0;
      stage_q     <= '0;
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      win_valid_q <= 1'b0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      gray_req_q <= 1'b0;
      pend_q     <= gray_req_q;

      case (state_q)
        ST_IDLE: begin
          if (gray_ready) state_q <= ST_ROW_INIT;
        end

        ST_ROW_INIT, ST_COL_FETCH: begin
          if (issue) begin
            gray_req_q  <= 1'b1;
            gray_addr_q <= {req_row, req_col};
            if (iss_row_q == 2'd2) begin
              iss_row_q <= '0;
              iss_col_q <= iss_col_q + 2'd1;
            end else begin
              iss_row_q <= iss_row_q + 2'd1;
            end
          end

          // Capture proceeds even if gray_ready has dropped: the datum was already requested.
          if (pend_q) begin
            if (cap_row_q == 2'd0) stage_q[15:8] <= gray_data;
            if (cap_row_q == 2'd1) stage_q[7:0]  <= gray_data;
            if (cap_row_q == 2'd2) begin
              cap_row_q <= '0;
              cap_col_q <= cap_col_q + 2'd1;
            end else begin
              cap_row_q <= cap_row_q + 2'd1;
            end
          end

          if (win_done) begin
            win_valid_q <= 1'b1;
            state_q     <= ST_WIN_OUT;
          end
        end

        ST_WIN_OUT: begin
          win_valid_q <= 1'b0;
          state_q     <= ST_WAIT_RES;
        end

        ST_WAIT_RES: begin
          if (res_valid) begin
            lbp_valid_q <= 1'b1;
            lbp_addr_q  <= {r_q, c_q};
            lbp_data_q  <= res_data;
            state_q     <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          lbp_valid_q <= 1'b0;
          iss_row_q   <= '0;
          iss_col_q   <= '0;
          cap_row_q   <= '0;
          cap_col_q   <= '0;
          if (c_q < C_LAST) begin
            c_q     <= c_q + CW'(1);
            state_q <= ST_COL_FETCH;
          end else if (r_q < R_LAST) begin
            r_q     <= r_q + RW'(1);
            c_q     <= CW'(1);
            state_q <= ST_ROW_INIT;
          end else begin
            finish_q <= 1'b1;
            state_q  <= ST_DONE;
          end
        end

        ST_DONE: begin
          state_q <= ST_DONE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gray_req  = gray_req_q;
  assign gray_addr = gray_addr_q;
  assign win_valid = win_valid_q;
  assign lbp_valid = lbp_valid_q;
  assign lbp_addr  = lbp_addr_q;
  assign lbp_data  = lbp_data_q;
  assign finish    = finish_q;

endmodule
